// File: rtl/ioctl_cfg_router.sv
// HPS download front-end: routes the ioctl byte stream into DIP bytes, mod registers
// and a packed, handshaked ROM write port with an end-of-download flush.
module ioctl_cfg_router #(
   parameter int DIP_BYTES      = 8,
   parameter int DIP_INDEX      = 254,
   parameter int MOD_COUNT      = 2,
   parameter int MOD_BASE_INDEX = 1,
   parameter int ROM_INDEX      = 0,
   parameter int DATA_W         = 16,
   parameter int ADDR_W         = 25,
   localparam int L             = DATA_W / 8,
   localparam int LB            = (L > 1) ? $clog2(L) : 0,
   localparam int LW            = (LB > 0) ? LB : 1,
   localparam int WA_W          = ADDR_W - LB
) (
   input  logic                   clk_sys,
   input  logic                   reset,
   input  logic                   ioctl_download,
   input  logic                   ioctl_wr,
   input  logic [ADDR_W-1:0]      ioctl_addr,
   input  logic [7:0]             ioctl_dout,
   input  logic [7:0]             ioctl_index,
   output logic                   ioctl_wait,
   output logic [DIP_BYTES*8-1:0] dip_out,
   output logic [MOD_COUNT*8-1:0] mod_out,
   output logic [MOD_COUNT-1:0]   mod_valid,
   output logic                   rom_wr,
   input  logic                   rom_ready,
   output logic [WA_W-1:0]        rom_addr,
   output logic [DATA_W-1:0]      rom_data,
   output logic [L-1:0]           rom_be,
   output logic                   rom_done,
   output logic [ADDR_W-1:0]      rom_bytes,
   output logic                   overflow
);

   localparam logic [7:0] DIP_IDX = 8'(DIP_INDEX);
   localparam logic [7:0] ROM_IDX = 8'(ROM_INDEX);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH, S_DONE} state_t;

   state_t                 state_q, state_d;
   logic                   dl_q, dl_d;
   logic                   pend_q, pend_d;
   logic [7:0]             idx_q, idx_d;
   logic [DIP_BYTES*8-1:0] dip_q, dip_d;
   logic [MOD_COUNT*8-1:0] mod_q, mod_d;
   logic [MOD_COUNT-1:0]   modv_q, modv_d;
   logic [DATA_W-1:0]      buf_data_q, buf_data_d;
   logic [L-1:0]           buf_be_q, buf_be_d;
   logic [WA_W-1:0]        buf_waddr_q, buf_waddr_d;
   logic                   out_vld_q, out_vld_d;
   logic [DATA_W-1:0]      out_data_q, out_data_d;
   logic [L-1:0]           out_be_q, out_be_d;
   logic [WA_W-1:0]        out_addr_q, out_addr_d;
   logic                   ovf_q, ovf_d;
   logic [ADDR_W-1:0]      cnt_q, cnt_d;

   logic                   dl_rise, dl_fall, out_free, buf_vld, rom_byte;
   logic                   same_word, new_word, need_out;
   logic [LW-1:0]          lane;
   logic [WA_W-1:0]        waddr;
   logic [L-1:0]           merged_be;
   logic [DATA_W-1:0]      merged_data;

   always_comb begin
      dip_d       = dip_q;
      mod_d       = mod_q;
      modv_d      = modv_q;
      state_d     = state_q;
      dl_d        = ioctl_download;
      pend_d      = pend_q;
      idx_d       = idx_q;
      buf_data_d  = buf_data_q;
      buf_be_d    = buf_be_q;
      buf_waddr_d = buf_waddr_q;
      out_data_d  = out_data_q;
      out_be_d    = out_be_q;
      out_addr_d  = out_addr_q;
      ovf_d       = ovf_q;
      cnt_d       = cnt_q;

      dl_rise   = ioctl_download & ~dl_q;
      dl_fall   = ~ioctl_download & dl_q;
      out_free  = ~out_vld_q | rom_ready;
      out_vld_d = out_vld_q & ~rom_ready;
      buf_vld   = |buf_be_q;
      rom_byte  = ioctl_wr && (state_q == S_LOAD) && (ioctl_index == idx_q);

      lane      = (LB > 0) ? ioctl_addr[LW-1:0] : '0;
      waddr     = ioctl_addr[ADDR_W-1:LB];
      same_word = buf_vld && (waddr == buf_waddr_q);
      new_word  = buf_vld && (waddr != buf_waddr_q);

      // Merge the incoming byte into the current word (or a fresh one)
      merged_be   = same_word ? buf_be_q : '0;
      merged_data = same_word ? buf_data_q : '0;
      for (int i = 0; i < L; i++) begin
         if (lane == LW'(i)) begin
            merged_be[i]          = 1'b1;
            merged_data[8*i +: 8] = ioctl_dout;
         end
      end
      need_out = new_word || (&merged_be);

      for (int i = 0; i < DIP_BYTES; i++) begin
         if (ioctl_wr && ioctl_index == DIP_IDX && ioctl_addr == ADDR_W'(i))
            dip_d[8*i +: 8] = ioctl_dout;
      end
      for (int k = 0; k < MOD_COUNT; k++) begin
         if (ioctl_wr && ioctl_index == 8'(MOD_BASE_INDEX + k) && ioctl_addr == '0) begin
            mod_d[8*k +: 8] = ioctl_dout;
            modv_d[k]       = 1'b1;
         end
      end

      unique case (state_q)
         S_IDLE: begin
            pend_d = 1'b0;
            if (ioctl_download && ioctl_index == ROM_IDX && (dl_rise || pend_q)) begin
               state_d = S_LOAD;
               idx_d   = ioctl_index;
               cnt_d   = '0;
            end
         end
         S_LOAD: begin
            if (rom_byte) begin
               if (need_out && !out_free) begin
                  ovf_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + 1'b1;
                  if (new_word) begin
                     out_vld_d  = 1'b1;
                     out_data_d = buf_data_q;
                     out_be_d   = buf_be_q;
                     out_addr_d = buf_waddr_q;
                  end
                  if (&merged_be) begin
                     out_vld_d  = 1'b1;
                     out_data_d = merged_data;
                     out_be_d   = merged_be;
                     out_addr_d = waddr;
                     buf_be_d   = '0;
                  end else begin
                     buf_data_d  = merged_data;
                     buf_be_d    = merged_be;
                     buf_waddr_d = waddr;
                  end
               end
            end
            if (dl_fall) state_d = S_FLUSH;
         end
         S_FLUSH: begin
            if (dl_rise && ioctl_index == ROM_IDX) pend_d = 1'b1;
            if (buf_vld) begin
               if (out_free) begin
                  out_vld_d  = 1'b1;
                  out_data_d = buf_data_q;
                  out_be_d   = buf_be_q;
                  out_addr_d = buf_waddr_q;
                  buf_be_d   = '0;
               end
            end else if (out_free) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (dl_rise && ioctl_index == ROM_IDX) pend_d = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         dl_q        <= 1'b0;
         pend_q      <= 1'b0;
         idx_q       <= '0;
         dip_q       <= '0;
         mod_q       <= '0;
         modv_q      <= '0;
         buf_data_q  <= '0;
         buf_be_q    <= '0;
         buf_waddr_q <= '0;
         out_vld_q   <= 1'b0;
         out_data_q  <= '0;
         out_be_q    <= '0;
         out_addr_q  <= '0;
         ovf_q       <= 1'b0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         dl_q        <= dl_d;
         pend_q      <= pend_d;
         idx_q       <= idx_d;
         dip_q       <= dip_d;
         mod_q       <= mod_d;
         modv_q      <= modv_d;
         buf_data_q  <= buf_data_d;
         buf_be_q    <= buf_be_d;
         buf_waddr_q <= buf_waddr_d;
         out_vld_q   <= out_vld_d;
         out_data_q  <= out_data_d;
         out_be_q    <= out_be_d;
         out_addr_q  <= out_addr_d;
         ovf_q       <= ovf_d;
         cnt_q       <= cnt_d;
      end
   end

   assign ioctl_wait = out_vld_q;
   assign rom_wr     = out_vld_q;
   assign rom_addr   = out_addr_q;
   assign rom_data   = out_data_q;
   assign rom_be     = out_be_q;
   assign rom_done   = (state_q == S_DONE);
   assign rom_bytes  = cnt_q;
   assign overflow   = ovf_q;
   assign dip_out    = dip_q;
   assign mod_out    = mod_q;
   assign mod_valid  = modv_q;

endmodule

// File: tb/tb_ioctl_cfg_router.sv
// Directed bench for ioctl_cfg_router: a 16-bit and a 32-bit instance share one ioctl stream.
module tb_ioctl_cfg_router;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, dl, wr, rdy;
   logic [24:0] addr;
   logic [7:0]  dout, idx;

   logic        a_wait, a_wr, a_done, a_ovf;
   logic [63:0] a_dip;
   logic [15:0] a_mod;
   logic [1:0]  a_modv;
   logic [23:0] a_addr;
   logic [15:0] a_data;
   logic [1:0]  a_be;
   logic [24:0] a_bytes;

   logic        b_wait, b_wr, b_done, b_ovf;
   logic [63:0] b_dip;
   logic [15:0] b_mod;
   logic [1:0]  b_modv;
   logic [22:0] b_addr;
   logic [31:0] b_data;
   logic [3:0]  b_be;
   logic [24:0] b_bytes;

   ioctl_cfg_router #(.DATA_W(16)) u16 (
      .clk_sys(clk), .reset(reset), .ioctl_download(dl), .ioctl_wr(wr),
      .ioctl_addr(addr), .ioctl_dout(dout), .ioctl_index(idx), .ioctl_wait(a_wait),
      .dip_out(a_dip), .mod_out(a_mod), .mod_valid(a_modv), .rom_wr(a_wr),
      .rom_ready(rdy), .rom_addr(a_addr), .rom_data(a_data), .rom_be(a_be),
      .rom_done(a_done), .rom_bytes(a_bytes), .overflow(a_ovf));

   ioctl_cfg_router #(.DATA_W(32)) u32 (
      .clk_sys(clk), .reset(reset), .ioctl_download(dl), .ioctl_wr(wr),
      .ioctl_addr(addr), .ioctl_dout(dout), .ioctl_index(idx), .ioctl_wait(b_wait),
      .dip_out(b_dip), .mod_out(b_mod), .mod_valid(b_modv), .rom_wr(b_wr),
      .rom_ready(rdy), .rom_addr(b_addr), .rom_data(b_data), .rom_be(b_be),
      .rom_done(b_done), .rom_bytes(b_bytes), .overflow(b_ovf));

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wbyte(input logic [7:0] i, input logic [24:0] a, input logic [7:0] d);
      idx  = i;
      addr = a;
      dout = d;
      wr   = 1'b1;
      tick();
      wr   = 1'b0;
   endtask

   typedef struct {
      logic [7:0]  idx;
      logic [24:0] addr;
      logic [7:0]  data;
      logic [63:0] dip;
      logic [15:0] mod;
      logic [1:0]  modv;
   } vec_t;

   vec_t vt[15];

   initial begin
      vt[0]  = '{8'hFE, 25'd0, 8'hA0, 64'h00000000_000000A0, 16'h0000, 2'b00};
      vt[1]  = '{8'hFE, 25'd1, 8'hA1, 64'h00000000_0000A1A0, 16'h0000, 2'b00};
      vt[2]  = '{8'hFE, 25'd2, 8'hA2, 64'h00000000_00A2A1A0, 16'h0000, 2'b00};
      vt[3]  = '{8'hFE, 25'd3, 8'hA3, 64'h00000000_A3A2A1A0, 16'h0000, 2'b00};
      vt[4]  = '{8'hFE, 25'd4, 8'hA4, 64'h000000A4_A3A2A1A0, 16'h0000, 2'b00};
      vt[5]  = '{8'hFE, 25'd5, 8'hA5, 64'h0000A5A4_A3A2A1A0, 16'h0000, 2'b00};
      vt[6]  = '{8'hFE, 25'd6, 8'hA6, 64'h00A6A5A4_A3A2A1A0, 16'h0000, 2'b00};
      vt[7]  = '{8'hFE, 25'd7, 8'hA7, 64'hA7A6A5A4_A3A2A1A0, 16'h0000, 2'b00};
      vt[8]  = '{8'hFE, 25'd8, 8'hA8, 64'hA7A6A5A4_A3A2A1A0, 16'h0000, 2'b00};
      vt[9]  = '{8'hFE, 25'd9, 8'hA9, 64'hA7A6A5A4_A3A2A1A0, 16'h0000, 2'b00};
      vt[10] = '{8'h01, 25'd0, 8'h5A, 64'hA7A6A5A4_A3A2A1A0, 16'h005A, 2'b01};
      vt[11] = '{8'h02, 25'd0, 8'h3C, 64'hA7A6A5A4_A3A2A1A0, 16'h3C5A, 2'b11};
      vt[12] = '{8'h02, 25'd3, 8'hFF, 64'hA7A6A5A4_A3A2A1A0, 16'h3C5A, 2'b11};
      vt[13] = '{8'h03, 25'd0, 8'h77, 64'hA7A6A5A4_A3A2A1A0, 16'h3C5A, 2'b11};
      vt[14] = '{8'hFE, 25'd2, 8'h55, 64'hA7A6A5A4_A355A1A0, 16'h3C5A, 2'b11};

      reset = 1'b1; dl = 1'b0; wr = 1'b0; rdy = 1'b0;
      addr = '0; dout = '0; idx = '0;
      tick(); tick();
      chk("rst_rom_wr", a_wr, 0);
      chk("rst_wait", a_wait, 0);
      chk("rst_dip", a_dip, 0);
      chk("rst_mod_valid", a_modv, 0);
      chk("rst_done", a_done, 0);
      chk("rst_bytes", a_bytes, 0);
      reset = 1'b0;
      tick();

      // DIP and mod routing under a non-ROM download
      idx = 8'hFE; dl = 1'b1;
      tick();
      for (int i = 0; i < 15; i++) begin
         wbyte(vt[i].idx, vt[i].addr, vt[i].data);
         chk($sformatf("dip_v%0d", i), a_dip, vt[i].dip);
         chk($sformatf("mod_v%0d", i), a_mod, vt[i].mod);
         chk($sformatf("modv_v%0d", i), a_modv, vt[i].modv);
         chk($sformatf("romwr_v%0d", i), a_wr, 0);
      end
      dl = 1'b0;
      tick();

      // Basic 16-bit packing with flush of a trailing partial word
      rdy = 1'b1; idx = 8'h00; dl = 1'b1;
      tick();
      wbyte(8'h00, 25'd0, 8'h11);
      chk("p_buf_rom_wr", a_wr, 0);
      wbyte(8'h00, 25'd1, 8'h22);
      chk("p_w0_wr", a_wr, 1);
      chk("p_w0_addr", a_addr, 0);
      chk("p_w0_data", a_data, 16'h2211);
      chk("p_w0_be", a_be, 2'b11);
      chk("p_w0_wait", a_wait, 1);
      chk("p_w0_bytes", a_bytes, 2);
      wbyte(8'h00, 25'd2, 8'h33);
      chk("p_acc_wr", a_wr, 0);
      dl = 1'b0;
      tick();
      chk("p_flush_done0", a_done, 0);
      tick();
      chk("p_w1_wr", a_wr, 1);
      chk("p_w1_addr", a_addr, 1);
      chk("p_w1_data", a_data, 16'h0033);
      chk("p_w1_be", a_be, 2'b01);
      chk("p32_w_wr", b_wr, 1);
      chk("p32_w_data", b_data, 32'h00332211);
      chk("p32_w_be", b_be, 4'b0111);
      tick();
      chk("p_done", a_done, 1);
      chk("p_done_wr", a_wr, 0);
      tick();
      chk("p_done_pulse", a_done, 0);
      chk("p_bytes", a_bytes, 3);

      // Stall with rom_ready low; the completing byte is dropped
      rdy = 1'b0; idx = 8'h00; dl = 1'b1;
      tick();
      chk("s_bytes_clr", a_bytes, 0);
      wbyte(8'h00, 25'd0, 8'hAA);
      wbyte(8'h00, 25'd1, 8'hBB);
      chk("s_wait1", a_wait, 1);
      wbyte(8'h00, 25'd2, 8'hCC);
      chk("s_wait2", a_wait, 1);
      chk("s_ovf_pre", a_ovf, 0);
      wbyte(8'h00, 25'd3, 8'hDD);
      chk("s_wait3", a_wait, 1);
      chk("s_ovf", a_ovf, 1);
      tick();
      chk("s_wait4", a_wait, 1);
      tick();
      chk("s_wait5", a_wait, 1);
      chk("s_bytes", a_bytes, 3);
      chk("s_hold_data", a_data, 16'hBBAA);
      chk("s_hold_addr", a_addr, 0);
      rdy = 1'b1;
      tick();
      chk("s_acc_wr", a_wr, 0);
      chk("s_ovf_sticky", a_ovf, 1);
      dl = 1'b0;
      tick();
      tick();
      chk("s_w1_wr", a_wr, 1);
      chk("s_w1_addr", a_addr, 1);
      chk("s_w1_data", a_data, 16'h00CC);
      chk("s_w1_be", a_be, 2'b01);
      tick();
      chk("s_done", a_done, 1);
      tick();

      // Non-contiguous bytes on the 32-bit instance
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tick();
      rdy = 1'b1; idx = 8'h00; dl = 1'b1;
      tick();
      wbyte(8'h00, 25'd0, 8'h12);
      chk("n_buf_wr", b_wr, 0);
      wbyte(8'h00, 25'd6, 8'h34);
      chk("n_w0_wr", b_wr, 1);
      chk("n_w0_addr", b_addr, 0);
      chk("n_w0_be", b_be, 4'b0001);
      chk("n_w0_data", b_data, 32'h00000012);
      dl = 1'b0;
      tick();
      chk("n_acc_wr", b_wr, 0);
      tick();
      chk("n_w1_wr", b_wr, 1);
      chk("n_w1_addr", b_addr, 1);
      chk("n_w1_be", b_be, 4'b0100);
      chk("n_w1_data", b_data, 32'h00340000);
      tick();
      chk("n_done", b_done, 1);
      tick();

      // Reset in LOAD with a partial buffer
      rdy = 1'b1; idx = 8'h00; dl = 1'b1;
      tick();
      wbyte(8'hFE, 25'd0, 8'h66);
      wbyte(8'h01, 25'd0, 8'h99);
      wbyte(8'h00, 25'd0, 8'h55);
      chk("r_pre_bytes", a_bytes, 1);
      chk("r_pre_dip", a_dip, 64'h66);
      chk("r_pre_modv", a_modv, 2'b01);
      reset = 1'b1; dl = 1'b0;
      #1;
      chk("r_async_wr", a_wr, 0);
      chk("r_async_bytes", a_bytes, 0);
      chk("r_async_dip", a_dip, 0);
      chk("r_async_mod", a_mod, 0);
      chk("r_async_modv", a_modv, 0);
      chk("r_async_ovf", a_ovf, 0);
      tick();
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk($sformatf("r_no_done%0d", i), a_done, 0);
         chk($sformatf("r_no_wr%0d", i), a_wr, 0);
      end
      idx = 8'h00; dl = 1'b1;
      tick();
      chk("r_new_bytes0", a_bytes, 0);
      wbyte(8'h00, 25'd0, 8'h01);
      chk("r_new_bytes1", a_bytes, 1);
      wbyte(8'h00, 25'd1, 8'h02);
      chk("r_new_data", a_data, 16'h0201);
      chk("r_new_be", a_be, 2'b11);
      dl = 1'b0;
      tick();
      tick();
      chk("r_new_done", a_done, 1);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/ioctl_cfg_router.md
Name: ioctl_cfg_router

Overview:
Generalised HPS download front-end that sits between hps_io and an arcade core.
- Demultiplexes the ioctl byte stream by ioctl_index into a parametrised DIP-switch bank, a parametrised set of per-game mod registers, and a ROM write port.
- Packs ROM bytes into DATA_W-wide words with byte enables and holds each word for a ready/valid handshake to the core.
- Flushes any partial word at end of download, then issues a single rom_done pulse.

Parameters:
DIP_BYTES, 8, number of DIP bytes captured from index DIP_INDEX
DIP_INDEX, 254, ioctl_index carrying DIP settings
MOD_COUNT, 2, number of mod registers
MOD_BASE_INDEX, 1, index of mod register 0; register k uses MOD_BASE_INDEX+k
ROM_INDEX, 0, ioctl_index carrying ROM data
DATA_W, 16, packed ROM word width; multiple of 8, range 8..64
ADDR_W, 25, byte-address width

Ports:
clk_sys  in  1  system clock; all logic on rising edge
reset  in  1  asynchronous, active-high; clears all state
ioctl_download  in  1  download active
ioctl_wr  in  1  byte strobe, one cycle per byte
ioctl_addr  in  25  byte address
ioctl_dout  in  8  byte data
ioctl_index  in  8  download index
ioctl_wait  out  1  stall request back to hps_io
dip_out  out  DIP_BYTES*8  byte i at [8i+7:8i]
mod_out  out  MOD_COUNT*8  mod register k at [8k+7:8k]
mod_valid  out  MOD_COUNT  sticky; register k has been written
rom_wr  out  1  valid: rom_addr/rom_data/rom_be hold a word
rom_ready  in  1  core accepts the word when rom_wr & rom_ready
rom_addr  out  ADDR_W-log2(DATA_W/8)  word address
rom_data  out  DATA_W  packed word, little-endian byte lanes
rom_be  out  DATA_W/8  lane enables
rom_done  out  1  one-cycle pulse after the final word is accepted
rom_bytes  out  ADDR_W  bytes accepted in the current/last ROM download
overflow  out  1  sticky; a byte was dropped due to a protocol violation

Behaviour:
- Reset values: all outputs 0; dip_out, mod_out and mod_valid 0; FSM in IDLE. Reset mid-download discards the partial buffer and the pending word and suppresses rom_done.
- DIP path: ioctl_wr with index DIP_INDEX and addr < DIP_BYTES writes dip_out byte [addr] on the next edge. Writes at addr >= DIP_BYTES are ignored.
- Mod path: ioctl_wr with index MOD_BASE_INDEX+k (k < MOD_COUNT) and addr == 0 loads mod_out[k] and sets mod_valid[k]. Writes at nonzero addr are ignored.
- DIP and mod paths are independent of the FSM.
- Packing, L = DATA_W/8:
  - lane = addr mod L; waddr = addr / L.
  - A partial buffer holds data, be and waddr.
  - A byte whose waddr differs from the buffer's, while the buffer is non-empty, first moves the buffer to the output register with its partial be, then starts a new buffer.
  - A byte that completes all L lanes moves the word straight to the output register in the same edge.
  - DATA_W=8: every byte is emitted directly.
- Output register:
  - rom_wr is high while the register is occupied; it clears on the edge where rom_ready=1.
  - Data, addr and be are stable while rom_wr=1.
  - ioctl_wait = rom_wr (registered).
  - A byte arriving while rom_wr=1 and needing the output register is dropped, sets overflow, and is not counted.
- rom_bytes: cleared at ROM download start; +1 per accepted ROM byte; wraps at 2^ADDR_W.
- FSM:
  - IDLE → LOAD on rising ioctl_download with index==ROM_INDEX; the index is latched at that edge.
  - LOAD → FLUSH on falling ioctl_download.
  - FLUSH: a non-empty buffer moves to the output register once it is empty. When both are empty, go to DONE.
  - DONE: rom_done=1 for one cycle, then IDLE.
  - A new download rising in FLUSH or DONE is deferred until IDLE.
  - Non-ROM downloads never leave IDLE.
- Simultaneous rom_ready acceptance and a buffer→output move on the same edge is legal: the new word loads and rom_wr stays 1.

Test Plan:
- Reset, then DIP bytes at index 254, addr 0..9, data 0xA0+addr → dip_out bytes 0..7 = A0..A7; addr 8/9 ignored; mod_valid=0.
- Index 1 addr0=0x5A, index 2 addr0=0x3C, index 2 addr3=0xFF → mod_out=0x3C5A, mod_valid=2'b11.
- DATA_W=16, ROM index 0, bytes 11,22,33 at addr 0..2, rom_ready=1 → word0 addr0 data 0x2211 be 11; after download falls, word1 addr1 data 0x0033 be 01; rom_done one cycle later; rom_bytes=3.
- rom_ready held 0 for 5 cycles after a complete word → ioctl_wait=1 throughout; one extra ioctl_wr at addr 2,3 during stall → overflow=1, rom_bytes excludes dropped bytes.
- Non-contiguous bytes at addr 0 then addr 6 (DATA_W=32) → word addr0 be 0001 emitted, then partial at addr1 lane2.
- Assert reset in LOAD with partial buffer → all outputs 0, no rom_done, subsequent download starts rom_bytes at 0.
